fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 9-bit pipelined CPU.
- Drives the PC into the combinational instruction ROM and registers the returned word into the IF/ID pipeline register.
- Honours stalls from the hazard unit and PC redirects (branch/jump) from execute.
- Stops fetching when the HALT opcode is fetched.

Parameters:
- PC_W, 16, program-counter width
- INSTR_W, 9, instruction width ({opcode, operand})
- OP_W, 5, opcode field width (instr[INSTR_W-1 -: OP_W])
- START_PC, 16'd1, first fetch address after start
- HALT_OP, 5'b11010, opcode that stops fetch

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  one-cycle pulse; begins execution at START_PC
- stall  in  1  hazard unit: hold PC and IF/ID contents
- redirect_valid  in  1  execute resolved a taken branch/jump this cycle
- redirect_pc  in  PC_W  target address of redirect
- rom_pc  out  PC_W  address to instruction ROM (= pc register)
- rom_instr  in  INSTR_W  ROM data, combinational from rom_pc
- if_valid  out  1  IF/ID register holds a live instruction
- if_instr  out  INSTR_W  IF/ID instruction
- if_pc  out  PC_W  PC of if_instr
- halted  out  1  HALT fetched, fetch frozen
- busy  out  1  state is RUN or HALTED

Behaviour:
- Reset (async, any state): state=IDLE, pc=START_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, busy=0. Takes effect immediately, including mid-fetch.
- States: IDLE, RUN, HALTED.
- ROM latency 0: rom_pc=pc; rom_instr is sampled the same cycle and appears on if_* one clock later.
- IDLE:
  - start=1: pc<=START_PC, go RUN; if_valid stays 0.
  - Other inputs (stall, redirect) ignored.
- RUN, priority redirect > stall > normal:
  - redirect_valid=1: pc<=redirect_pc; if_valid<=0 (flush the wrong-path instruction); stay RUN. Applies even if stall=1.
  - stall=1 (no redirect): pc, if_valid, if_instr, if_pc all hold.
  - Normal: if_instr<=rom_instr, if_pc<=pc, if_valid<=1, pc<=pc+1 (mod 2^PC_W; 16'hFFFF wraps to 0).
  - Normal and opcode(rom_instr)==HALT_OP: HALT is latched into IF/ID (if_valid=1) so it travels down the pipe; pc holds at the HALT address; go HALTED.
- HALTED:
  - halted=1; pc holds.
  - Next non-stalled cycle: if_valid<=0 (no duplicate issue).
  - redirect_valid=1: the HALT was on a wrong path; pc<=redirect_pc, if_valid<=0, halted<=0, go RUN.
  - start ignored; only reset or redirect leaves HALTED.
- start while RUN: ignored.
- Simultaneous start and reset: reset wins.
- busy=1 in RUN and HALTED, 0 in IDLE.

Optional Feature:
- Macro: FETCH_SEQUENCER_PERF_CNT_EN.
- Defined: adds outputs fetch_count[15:0] and stall_count[15:0], both async-reset to 0.
  - fetch_count increments on each cycle that sets if_valid<=1.
  - stall_count increments on each cycle in RUN with stall=1 and redirect_valid=0.
  - Both saturate at 16'hFFFF.
  - Both clear to 0 on a start accepted in IDLE.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package cpu_isa_pkg:
  - all 5-bit opcode constants, including HALT_OP=5'b11010
  - INSTR_W, OP_W, PC_W
  - fetch state enum {IDLE, RUN, HALTED}
- Natural sub-module: fetch_perf_counter (saturating 16-bit counter with inc/clear), instantiated twice under the macro.
- No other sub-modules.

Test Plan:
- Reset, start pulse, no stall, ROM word at PC1=9'b00110_0001 -> rom_pc sequence 1,2,3…; cycle after start+1: if_valid=1, if_pc=1, if_instr=9'h061.
- stall held 3 cycles at pc=5 -> rom_pc stays 5; if_pc/if_instr unchanged for 3 cycles; next cycle resumes with if_pc=5, rom_pc=6.
- redirect_valid with redirect_pc=16'd74 while stall=1 -> next cycle rom_pc=74, if_valid=0; following cycle if_pc=74.
- ROM returns {HALT_OP,4'b0} at pc=79 -> if_instr=9'h1A0, if_valid=1, halted=1, rom_pc stays 79; next cycle if_valid=0. Then redirect_pc=16'd68 -> halted=0, RUN, rom_pc=68.
- pc preset to 16'hFFFF via redirect, no stall -> next rom_pc=16'h0000, if_pc=16'hFFFF.
- reset asserted mid-RUN between clock edges -> immediately if_valid=0, halted=0, busy=0, rom_pc=1. With FETCH_SEQUENCER_PERF_CNT_EN: counters read 0.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 9-bit pipelined CPU: field widths, opcodes
// and the fetch-stage state encoding.
package cpu_isa_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 9;
  localparam int OP_W    = 5;

  localparam logic [OP_W-1:0] NOP_OP  = 5'b00000;
  localparam logic [OP_W-1:0] LDI_OP  = 5'b00001;
  localparam logic [OP_W-1:0] ADD_OP  = 5'b00010;
  localparam logic [OP_W-1:0] SUB_OP  = 5'b00011;
  localparam logic [OP_W-1:0] AND_OP  = 5'b00100;
  localparam logic [OP_W-1:0] OR_OP   = 5'b00101;
  localparam logic [OP_W-1:0] LD_OP   = 5'b00110;
  localparam logic [OP_W-1:0] ST_OP   = 5'b00111;
  localparam logic [OP_W-1:0] BEQ_OP  = 5'b10000;
  localparam logic [OP_W-1:0] BNE_OP  = 5'b10001;
  localparam logic [OP_W-1:0] JMP_OP  = 5'b11000;
  localparam logic [OP_W-1:0] HALT_OP = 5'b11010;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_e;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: control inputs, ROM address/data and the IF/ID register.
// master = fetch_sequencer, slave = surrounding pipeline/ROM.
interface fetch_sequencer_if;
  import cpu_isa_pkg::*;

  logic               start;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    rom_pc;
  logic [INSTR_W-1:0] rom_instr;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               halted;
  logic               busy;

  modport master (
    input  start, stall, redirect_valid, redirect_pc, rom_instr,
    output rom_pc, if_valid, if_instr, if_pc, halted, busy
  );

  modport slave (
    output start, stall, redirect_valid, redirect_pc, rom_instr,
    input  rom_pc, if_valid, if_instr, if_pc, halted, busy
  );
endinterface

// File: rtl/fetch_perf_counter.sv
// Saturating 16-bit event counter with synchronous clear (clear beats inc).
module fetch_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && count_q != 16'hFFFF)
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives the ROM address, fills IF/ID, honours
// stall/redirect, freezes on HALT. FETCH_SEQUENCER_PERF_CNT_EN adds counters.
module fetch_sequencer
  import cpu_isa_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC = 16'd1
) (
  input  logic               clk,
  input  logic               reset,
`ifdef FETCH_SEQUENCER_PERF_CNT_EN
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count,
`endif
  fetch_sequencer_if.master  bus
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               halted_q, halted_d;
  logic               busy_q, busy_d;

  // NOTE: every target gets a default first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    halted_d   = halted_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_d    = START_PC;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc;
          if_valid_d = 1'b0;
        end else if (!bus.stall) begin
          if_instr_d = bus.rom_instr;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          // HALT parks the PC on itself so nothing past it is ever fetched.
          if (opcode_of(bus.rom_instr) == HALT_OP) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      HALTED: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc;
          if_valid_d = 1'b0;
          halted_d   = 1'b0;
          state_d    = RUN;
        end else if (!bus.stall) begin
          if_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= START_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rom_pc   = pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.halted   = halted_q;
  assign bus.busy     = busy_q;

`ifdef FETCH_SEQUENCER_PERF_CNT_EN
  logic perf_clr, fetch_inc, stall_inc;

  assign perf_clr  = (state_q == IDLE) && bus.start;
  assign fetch_inc = (state_q == RUN) && !bus.redirect_valid && !bus.stall;
  assign stall_inc = (state_q == RUN) && !bus.redirect_valid && bus.stall;

  fetch_perf_counter u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (fetch_inc),
    .count (fetch_count)
  );

  fetch_perf_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (stall_inc),
    .count (stall_count)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random
// start/stall/redirect traffic against a behavioural fetch model.
module tb_fetch_sequencer;
  import cpu_isa_pkg::*;

  localparam logic [15:0] START = 16'd1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

`ifdef FETCH_SEQUENCER_PERF_CNT_EN
  logic [15:0] fetch_count, stall_count;
`endif

  fetch_sequencer #(.START_PC(START)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef FETCH_SEQUENCER_PERF_CNT_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
`endif
    .bus         (bus)
  );

  logic [8:0] rom [0:65535];
  assign bus.rom_instr = rom[bus.rom_pc];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = fetching, 2 = frozen on HALT.
  int          m_mode;
  logic [15:0] m_pc, m_if_pc;
  logic [8:0]  m_if_instr;
  logic        m_valid, m_halted;
  int          m_fetches, m_stalls;

  task automatic model_reset();
    m_mode = 0; m_pc = START; m_if_pc = 0; m_if_instr = 0;
    m_valid = 0; m_halted = 0; m_fetches = 0; m_stalls = 0;
  endtask

  // Applies one clock edge worth of rules using the inputs now on the bus.
  task automatic model_step();
    logic [8:0] w;
    if (m_mode == 0) begin
      if (bus.start) begin
        m_mode = 1; m_pc = START; m_fetches = 0; m_stalls = 0;
      end
    end else if (bus.redirect_valid) begin
      m_pc = bus.redirect_pc; m_valid = 0; m_halted = 0; m_mode = 1;
    end else if (bus.stall) begin
      if (m_mode == 1 && m_stalls < 65535) m_stalls++;
    end else if (m_mode == 1) begin
      w = rom[m_pc];
      m_if_instr = w; m_if_pc = m_pc; m_valid = 1;
      if (m_fetches < 65535) m_fetches++;
      if (w[8:4] == HALT_OP) begin
        m_mode = 2; m_halted = 1;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("rom_pc",   32'(bus.rom_pc),   32'(m_pc));
    check("if_valid", 32'(bus.if_valid), 32'(m_valid));
    check("halted",   32'(bus.halted),   32'(m_halted));
    check("busy",     32'(bus.busy),     32'(m_mode != 0));
    if (m_valid) begin
      check("if_instr", 32'(bus.if_instr), 32'(m_if_instr));
      check("if_pc",    32'(bus.if_pc),    32'(m_if_pc));
    end
`ifdef FETCH_SEQUENCER_PERF_CNT_EN
    check("fetch_count", 32'(fetch_count), 32'(m_fetches));
    check("stall_count", 32'(stall_count), 32'(m_stalls));
`endif
  endtask

  // Inputs are held stable from negedge to negedge; the model sees the same values.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic st, input logic sl, input logic rv, input logic [15:0] rp);
    bus.start = st; bus.stall = sl; bus.redirect_valid = rv; bus.redirect_pc = rp;
  endtask

  initial begin
    logic [4:0] opc;
    for (int i = 0; i < 65536; i++) begin
      do opc = 5'($urandom_range(0, 31)); while (opc == HALT_OP);
      rom[i] = {opc, 4'($urandom)};
      if (i >= 200 && i <= 65000 && $urandom_range(0, 31) == 0) rom[i] = {HALT_OP, 4'($urandom)};
    end
    rom[1]  = 9'b00110_0001;
    rom[79] = {HALT_OP, 4'b0};

    drive(0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_if_instr", 32'(bus.if_instr), 32'h0);
    check("reset_if_pc",    32'(bus.if_pc),    32'h0);
    reset = 1'b0;

    // Start, then straight-line fetch from START.
    drive(1, 0, 1, 16'd300);
    step();
    check("start_no_valid", 32'(bus.if_valid), 32'h0);
    drive(0, 0, 0, 0);
    step();
    check("first_if_pc",    32'(bus.if_pc),    32'd1);
    check("first_if_instr", 32'(bus.if_instr), 32'h061);
    check("first_rom_pc",   32'(bus.rom_pc),   32'd2);
    repeat (3) step();

    // Stall at pc=5 for three cycles, start pulse ignored while running.
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rom_pc", 32'(bus.rom_pc), 32'd5);
      check("stall_if_pc",  32'(bus.if_pc),  32'd4);
    end
    drive(0, 0, 0, 0);
    step();
    check("resume_if_pc",  32'(bus.if_pc),  32'd5);
    check("resume_rom_pc", 32'(bus.rom_pc), 32'd6);

    // Redirect beats stall.
    drive(0, 1, 1, 16'd74);
    step();
    check("redir_rom_pc",   32'(bus.rom_pc),   32'd74);
    check("redir_if_valid", 32'(bus.if_valid), 32'h0);
    drive(0, 0, 0, 0);
    step();
    check("redir_if_pc", 32'(bus.if_pc), 32'd74);
    repeat (4) step();

    // HALT at 79.
    step();
    check("halt_if_instr", 32'(bus.if_instr), 32'h1A0);
    check("halt_valid",    32'(bus.if_valid), 32'h1);
    check("halt_flag",     32'(bus.halted),   32'h1);
    check("halt_rom_pc",   32'(bus.rom_pc),   32'd79);
    drive(1, 0, 0, 0);
    step();
    check("halt_no_dup", 32'(bus.if_valid), 32'h0);
    check("halt_hold",   32'(bus.halted),   32'h1);
    drive(0, 0, 1, 16'd68);
    step();
    check("unhalt_flag",   32'(bus.halted), 32'h0);
    check("unhalt_rom_pc", 32'(bus.rom_pc), 32'd68);

    // PC wrap.
    drive(0, 0, 1, 16'hFFFF);
    step();
    drive(0, 0, 0, 0);
    step();
    check("wrap_rom_pc", 32'(bus.rom_pc), 32'h0);
    check("wrap_if_pc",  32'(bus.if_pc),  32'hFFFF);
    repeat (2) step();

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(150, 400));
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, tgt);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
